// File: rtl/scaler_pkg.sv
// Shared constants and types for the F01-driven binary divider chain
// (stages FS02..FS33) and its input-activity watchdog.
package scaler_pkg;

  localparam int NSTAGES     = 32;
  localparam int FIRST_STAGE = 2;
  localparam int WDOG_WIDTH  = 7;
  localparam int WDOG_LIMIT  = 64;

  typedef logic [NSTAGES-1:0]    stage_vec_t;
  typedef logic [WDOG_WIDTH-1:0] wdog_cnt_t;

  // Bits that went 0->1 between two successive chain values.
  function automatic stage_vec_t rise_mask(input stage_vec_t old_v, input stage_vec_t new_v);
    return new_v & ~old_v;
  endfunction

  // Bits that went 1->0 between two successive chain values.
  function automatic stage_vec_t fall_mask(input stage_vec_t old_v, input stage_vec_t new_v);
    return old_v & ~new_v;
  endfunction

endpackage

// File: rtl/scaler_watchdog.sv
// FS01_n activity watchdog: counts clocks since the last FS01_n edge and
// raises SCAFAL once the input has been quiet for too long.
module scaler_watchdog
  import scaler_pkg::*;
(
  input  logic CLOCK,
  input  logic SIM_RST,
  input  logic FS01_n,
  output logic SCAFAL
);

  logic      prev_q,   prev_d;
  wdog_cnt_t cnt_q,    cnt_d;
  logic      scafal_q, scafal_d;
  logic      transition;

  always_comb begin
    transition = FS01_n ^ prev_q;
    prev_d     = FS01_n;
    cnt_d      = cnt_q;
    scafal_d   = 1'b0;
    if (transition) begin
      cnt_d = '0;
    end else begin
      // Saturate so a dead input keeps the flag set indefinitely.
      if (cnt_q != '1) cnt_d = cnt_q + wdog_cnt_t'(1);
      scafal_d = (cnt_q >= wdog_cnt_t'(WDOG_LIMIT));
    end
  end

  always_ff @(posedge CLOCK) begin
    if (SIM_RST) begin
      prev_q   <= 1'b1;
      cnt_q    <= '0;
      scafal_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      scafal_q <= scafal_d;
    end
  end

  assign SCAFAL = scafal_q;

endmodule

// File: rtl/scaler.sv
// Scaler: 32-stage synchronous binary divider advanced on each falling edge
// of F01 (FS01_n rising), with per-stage rise/fall pulses and a watchdog.
module scaler
  import scaler_pkg::*;
(
  input  logic               CLOCK,
  input  logic               SIM_RST,
  input  logic               FS01_n,
  input  logic               SCLRST,
  output logic [NSTAGES-1:0] FS,
  output logic [NSTAGES-1:0] FS_n,
  output logic [NSTAGES-1:0] FA,
  output logic [NSTAGES-1:0] FB,
  output logic               SCAFAL
);

  logic       prev_q, prev_d;
  stage_vec_t fs_q,   fs_d;
  stage_vec_t fa_q,   fa_d;
  stage_vec_t fb_q,   fb_d;
  logic       advance;

  // The whole chain updates in one step, so no ripple states are ever visible.
  always_comb begin
    advance = FS01_n & ~prev_q;
    prev_d  = FS01_n;
    fs_d    = fs_q;
    fa_d    = '0;
    fb_d    = '0;
    if (SCLRST) begin
      fs_d = '0;
    end else if (advance) begin
      fs_d = fs_q + stage_vec_t'(1);
      fa_d = rise_mask(fs_q, fs_d);
      fb_d = fall_mask(fs_q, fs_d);
    end
  end

  // prev_q resets to 1 so a high FS01_n right after reset is not an advance.
  always_ff @(posedge CLOCK) begin
    if (SIM_RST) begin
      prev_q <= 1'b1;
      fs_q   <= '0;
      fa_q   <= '0;
      fb_q   <= '0;
    end else begin
      prev_q <= prev_d;
      fs_q   <= fs_d;
      fa_q   <= fa_d;
      fb_q   <= fb_d;
    end
  end

  assign FS   = fs_q;
  assign FS_n = ~fs_q;
  assign FA   = fa_q;
  assign FB   = fb_q;

  scaler_watchdog u_watchdog (
    .CLOCK   (CLOCK),
    .SIM_RST (SIM_RST),
    .FS01_n  (FS01_n),
    .SCAFAL  (SCAFAL)
  );

endmodule

// File: tb/tb_scaler.sv
// Bench for scaler: directed and random FS01_n/SCLRST sequences checked
// every cycle against an event-count model of the divider and watchdog.
module tb_scaler;

  logic        clk = 1'b0;
  logic        sim_rst = 1'b0;
  logic        fs01_n = 1'b1;
  logic        sclrst = 1'b0;
  logic [31:0] fs, fs_n, fa, fb;
  logic        scafal;

  int total = 0;
  int bad   = 0;

  // Reference state: chain value as an event count, last input levels,
  // and the number of clocks since FS01_n last changed.
  logic [31:0] m_fs, m_fa, m_fb;
  logic        m_prev, m_wprev;
  int          since;

  int n_fa0, n_fb0, n_fa1;
  int rise_at;

  always #5 clk = ~clk;

  scaler dut (
    .CLOCK   (clk),
    .SIM_RST (sim_rst),
    .FS01_n  (fs01_n),
    .SCLRST  (sclrst),
    .FS      (fs),
    .FS_n    (fs_n),
    .FA      (fa),
    .FB      (fb),
    .SCAFAL  (scafal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".fs"},     fs,             m_fs);
    check({tag, ".fs_n"},   fs_n,           ~m_fs);
    check({tag, ".fa"},     fa,             m_fa);
    check({tag, ".fb"},     fb,             m_fb);
    check({tag, ".scafal"}, {31'd0, scafal}, {31'd0, (since >= 65)});
  endtask

  // One clock with the given inputs; outputs are compared at the next negedge.
  task automatic step(input logic f, input logic clr, input string tag);
    logic        ev, tr;
    logic [31:0] nxt;
    fs01_n = f;
    sclrst = clr;
    @(posedge clk);
    ev = f && !m_prev;
    tr = (f != m_wprev);
    m_prev  = f;
    m_wprev = f;
    m_fa = '0;
    m_fb = '0;
    if (clr) begin
      m_fs = '0;
    end else if (ev) begin
      nxt  = m_fs + 32'd1;
      m_fa = nxt & ~m_fs;
      m_fb = m_fs & ~nxt;
      m_fs = nxt;
    end
    if (tr) since = 0;
    else if (since < 1000) since++;
    @(negedge clk);
    check_all(tag);
    if (fa[0]) n_fa0++;
    if (fb[0]) n_fb0++;
    if (fa[1]) n_fa1++;
  endtask

  task automatic reset_cycle(input logic f, input logic clr);
    sim_rst = 1'b1;
    fs01_n  = f;
    sclrst  = clr;
    @(posedge clk);
    m_fs = '0; m_fa = '0; m_fb = '0;
    m_prev = 1'b1; m_wprev = 1'b1; since = 0;
    @(negedge clk);
    sim_rst = 1'b0;
    check_all("reset");
  endtask

  initial begin
    // Power-up reset with FS01_n high.
    reset_cycle(1'b1, 1'b0);

    // Square wave of period 40 for four periods: four advances.
    n_fa0 = 0; n_fb0 = 0; n_fa1 = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "sq_lo");
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "sq_hi");
    end
    check("sq.fs_final", fs, 32'd4);
    check("sq.fa0_count", n_fa0, 32'd2);
    check("sq.fb0_count", n_fb0, 32'd2);
    check("sq.fa1_count", n_fa1, 32'd1);
    check("sq.scafal", {31'd0, scafal}, 32'd0);

    // Quiet input: SCAFAL rises 65 clocks after the last transition.
    step(1'b0, 1'b0, "hold_edge");
    rise_at = -1;
    for (int i = 1; i <= 100; i++) begin
      step(1'b0, 1'b0, "hold");
      if (scafal && rise_at < 0) rise_at = i;
    end
    check("hold.rise_at", rise_at, 32'd65);
    step(1'b1, 1'b0, "hold_release");
    check("hold.scafal_clear", {31'd0, scafal}, 32'd0);
    check("hold.fs_after_event", fs, 32'd5);

    // Walk up to 0x123, then clear coincident with an advance.
    while (m_fs != 32'h123) begin
      step(1'b0, 1'b0, "walk_lo");
      step(1'b1, 1'b0, "walk_hi");
    end
    step(1'b0, 1'b0, "clr_setup");
    step(1'b1, 1'b1, "clr_with_event");
    check("clr.fs", fs, 32'd0);
    check("clr.fa", fa, 32'd0);
    check("clr.fb", fb, 32'd0);
    check("clr.scafal", {31'd0, scafal}, 32'd0);

    // Wrap-around from all-ones via a preloaded chain.
    step(1'b0, 1'b0, "wrap_setup");
    force dut.fs_q = 32'hFFFF_FFFF;
    #1;
    release dut.fs_q;
    m_fs = 32'hFFFF_FFFF;
    step(1'b1, 1'b0, "wrap");
    check("wrap.fs", fs, 32'd0);
    check("wrap.fa", fa, 32'd0);
    check("wrap.fb", fb, 32'hFFFF_FFFF);

    // Random runs of FS01_n levels with occasional clears.
    for (int seg = 0; seg < 40; seg++) begin
      logic f;
      int   len;
      f   = 1'($urandom_range(0, 1));
      len = (seg % 8 == 7) ? $urandom_range(60, 90) : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) step(f, ($urandom_range(0, 15) == 0), "rand");
    end

    // Reset mid-count at 0x1F, with SCLRST also high and FS01_n high.
    step(1'b0, 1'b1, "pre_clear");
    while (m_fs != 32'h1F) begin
      step(1'b1, 1'b0, "up_hi");
      step(1'b0, 1'b0, "up_lo");
    end
    check("mid.fs_before", fs, 32'h1F);
    reset_cycle(1'b1, 1'b1);
    check("mid.fs_after_rst", fs, 32'd0);
    step(1'b1, 1'b0, "post_rst");
    check("post_rst.no_event", fs, 32'd0);
    check("post_rst.fa", fa, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
